// File: rtl/exception_commit_ctrl.sv
// exception_commit_ctrl: picks the winning MEM-stage exception, drains the data bus,
// then pulses flush/CP0 update and hands a redirect PC to IF.
module exception_commit_ctrl #(
  parameter int          CNT_W    = 3,
  parameter logic [31:0] EXC_BASE = 32'h8000_0000,
  parameter logic [31:0] BEV_BASE = 32'hBFC0_0200
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        MEM_Valid,
  input  logic [18:0] MEM_ExceptType,
  input  logic [31:0] MEM_PC,
  input  logic        MEM_IsInDelaySlot,
  input  logic [31:0] MEM_VAddr,
  input  logic        CP0_Status_BEV,
  input  logic [31:0] CP0_EPC,
  input  logic        bus_req_fire,
  input  logic        bus_resp_fire,
  input  logic        redirect_ready,
  output logic        stall_o,
  output logic        flush_o,
  output logic        cp0_exc_we,
  output logic [4:0]  cp0_exccode,
  output logic [31:0] cp0_epc,
  output logic        cp0_bd,
  output logic        cp0_badvaddr_we,
  output logic [31:0] cp0_badvaddr,
  output logic        cp0_eret,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, REDIR} state_e;
  typedef enum logic [1:0] {K_EXC, K_ERET, K_REFETCH} kind_e;
  // ExcCode per vector bit; bit 0 is the highest priority (Interrupt), 17 = Eret, 18 = Refetch
  localparam logic [4:0] CODE [19] = '{5'd0, 5'd4, 5'd2, 5'd2, 5'd10, 5'd11, 5'd8, 5'd9, 5'd12,
                                       5'd13, 5'd4, 5'd5, 5'd2, 5'd2, 5'd3, 5'd3, 5'd1, 5'd0, 5'd0};
  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       sel, code_q;
  logic [31:0]      epc_q, epc_d, bva_q, bva_d, tgt_q, tgt_d;
  logic             bd_q, bvwe_q, bvwe_d, pc_cause, mem_cause, refill, trigger;
  always_comb begin
    sel = 5'd0;
    for (int i = 18; i >= 0; i--) if (MEM_ExceptType[i]) sel = 5'(i);
  end
  assign trigger   = resetn & MEM_Valid & (|MEM_ExceptType) & (state_q == IDLE);
  assign pc_cause  = sel inside {[5'd1:5'd3]};
  assign mem_cause = sel inside {[5'd10:5'd16]};
  assign refill    = sel == 5'd2 || sel == 5'd12 || sel == 5'd14;
  assign kind_d    = sel == 5'd17 ? K_ERET : sel == 5'd18 ? K_REFETCH : K_EXC;
  assign epc_d     = MEM_IsInDelaySlot ? MEM_PC - 32'd4 : MEM_PC;
  assign bva_d     = pc_cause ? MEM_PC : MEM_VAddr;
  assign bvwe_d    = pc_cause | mem_cause;
  assign tgt_d     = kind_d == K_ERET ? CP0_EPC : kind_d == K_REFETCH ? MEM_PC :
                     (CP0_Status_BEV ? BEV_BASE : EXC_BASE) + (refill ? 32'h0 : 32'h180);
  // Saturating in-flight count; simultaneous request and response cancel out
  assign cnt_d = (bus_req_fire & ~bus_resp_fire & ~&cnt_q) ? cnt_q + 1'b1 :
                 (bus_resp_fire & ~bus_req_fire & |cnt_q) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      kind_q <= K_EXC;
      code_q <= '0;
      epc_q  <= '0;
      bd_q   <= 1'b0;
      bva_q  <= '0;
      bvwe_q <= 1'b0;
      tgt_q  <= '0;
    end else if (trigger) begin
      kind_q <= kind_d;
      code_q <= CODE[sel];
      epc_q  <= epc_d;
      bd_q   <= MEM_IsInDelaySlot;
      bva_q  <= bva_d;
      bvwe_q <= bvwe_d;
      tgt_q  <= tgt_d;
    end
  end
  always_comb begin
    state_d = (trigger || state_q == DRAIN) ? (|cnt_d ? DRAIN : FLUSH) :
              state_q == FLUSH ? REDIR :
              (state_q == REDIR && redirect_ready) ? IDLE : state_q;
  end
  always_comb begin
    stall_o         = (state_q != IDLE) | trigger;
    flush_o         = state_q == FLUSH;
    cp0_exc_we      = state_q == FLUSH && kind_q == K_EXC;
    cp0_eret        = state_q == FLUSH && kind_q == K_ERET;
    cp0_exccode     = cp0_exc_we ? code_q : 5'd0;
    cp0_epc         = cp0_exc_we ? epc_q : 32'd0;
    cp0_bd          = cp0_exc_we & bd_q;
    cp0_badvaddr_we = cp0_exc_we & bvwe_q;
    cp0_badvaddr    = cp0_badvaddr_we ? bva_q : 32'd0;
    redirect_valid  = state_q == REDIR;
    redirect_pc     = redirect_valid ? tgt_q : 32'd0;
  end
endmodule

// File: tb/tb_exception_commit_ctrl.sv
// tb_exception_commit_ctrl: directed test-plan scenarios plus randomized traffic,
// every cycle checked against a transaction-level model of the commit sequence.
module tb_exception_commit_ctrl;
  logic        clk = 1'b0, resetn = 1'b0, MEM_Valid = 1'b0, MEM_IsInDelaySlot = 1'b0;
  logic [18:0] MEM_ExceptType = '0;
  logic [31:0] MEM_PC = '0, MEM_VAddr = '0, CP0_EPC = '0;
  logic        CP0_Status_BEV = 1'b0, bus_req_fire = 1'b0, bus_resp_fire = 1'b0, redirect_ready = 1'b0;
  logic        stall_o, flush_o, cp0_exc_we, cp0_bd, cp0_badvaddr_we, cp0_eret, redirect_valid;
  logic [4:0]  cp0_exccode;
  logic [31:0] cp0_epc, cp0_badvaddr, redirect_pc;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  exception_commit_ctrl dut (
    .clk(clk), .resetn(resetn), .MEM_Valid(MEM_Valid), .MEM_ExceptType(MEM_ExceptType),
    .MEM_PC(MEM_PC), .MEM_IsInDelaySlot(MEM_IsInDelaySlot), .MEM_VAddr(MEM_VAddr),
    .CP0_Status_BEV(CP0_Status_BEV), .CP0_EPC(CP0_EPC), .bus_req_fire(bus_req_fire),
    .bus_resp_fire(bus_resp_fire), .redirect_ready(redirect_ready), .stall_o(stall_o),
    .flush_o(flush_o), .cp0_exc_we(cp0_exc_we), .cp0_exccode(cp0_exccode), .cp0_epc(cp0_epc),
    .cp0_bd(cp0_bd), .cp0_badvaddr_we(cp0_badvaddr_we), .cp0_badvaddr(cp0_badvaddr),
    .cp0_eret(cp0_eret), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  // Model: an exception record waits for the bus to empty, flushes once, then offers a redirect
  bit          m_wait, m_flush, m_redir, m_bd, m_bvwe;
  int          m_cnt, m_kind, m_code;
  logic [31:0] m_epc, m_bva, m_tgt;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask
  function automatic logic [18:0] vbit(input int b);
    return 19'(1) << b;
  endfunction
  task automatic m_reset();
    m_wait = 0; m_flush = 0; m_redir = 0; m_cnt = 0;
  endtask
  task automatic m_latch();
    int b = -1;
    for (int i = 0; i < 19; i++) if (b < 0 && MEM_ExceptType[i]) b = i;
    case (b)
      0: m_code = 0;   1: m_code = 4;   2, 3: m_code = 2;  4: m_code = 10; 5: m_code = 11;
      6: m_code = 8;   7: m_code = 9;   8: m_code = 12;    9: m_code = 13; 10: m_code = 4;
      11: m_code = 5;  12, 13: m_code = 2; 14, 15: m_code = 3; 16: m_code = 1;
      default: m_code = 0;
    endcase
    m_kind = b == 17 ? 1 : b == 18 ? 2 : 0;
    m_epc  = MEM_IsInDelaySlot ? MEM_PC - 4 : MEM_PC;
    m_bd   = MEM_IsInDelaySlot;
    m_bvwe = (b >= 1 && b <= 3) || (b >= 10 && b <= 16);
    m_bva  = b <= 3 ? MEM_PC : MEM_VAddr;
    if (m_kind == 1) m_tgt = CP0_EPC;
    else if (m_kind == 2) m_tgt = MEM_PC;
    else m_tgt = (CP0_Status_BEV ? 32'hBFC0_0200 : 32'h8000_0000) + ((b == 2 || b == 12 || b == 14) ? 0 : 32'h180);
  endtask
  function automatic bit m_trig();
    return resetn && MEM_Valid && (|MEM_ExceptType) && !(m_wait || m_flush || m_redir);
  endfunction
  task automatic m_check();
    bit exc = m_flush && m_kind == 0;
    chk("stall", stall_o, m_wait || m_flush || m_redir || m_trig());
    chk("flush", flush_o, m_flush);
    chk("exc_we", cp0_exc_we, exc);
    chk("exccode", cp0_exccode, exc ? m_code : 0);
    chk("epc", cp0_epc, exc ? m_epc : 0);
    chk("bd", cp0_bd, exc && m_bd);
    chk("eret", cp0_eret, m_flush && m_kind == 1);
    chk("bva_we", cp0_badvaddr_we, exc && m_bvwe);
    chk("bva", cp0_badvaddr, (exc && m_bvwe) ? m_bva : 0);
    chk("rvalid", redirect_valid, m_redir);
    chk("rpc", redirect_pc, m_redir ? m_tgt : 0);
  endtask
  task automatic m_update();
    int nc;
    bit t, w, f, r;
    if (!resetn) begin
      m_reset();
      return;
    end
    t = m_trig(); w = m_wait; f = m_flush; r = m_redir;
    nc = m_cnt + int'(bus_req_fire) - int'(bus_resp_fire);
    nc = nc < 0 ? 0 : nc > 7 ? 7 : nc;
    m_redir = (r && !redirect_ready) || f;
    m_flush = (w || t) && nc == 0;
    m_wait  = (w || t) && nc != 0;
    if (t) m_latch();
    m_cnt = nc;
  endtask
  task automatic cyc();
    @(negedge clk);
    m_check();
    @(posedge clk);
    m_update();
    #1;
  endtask
  task automatic arm(input logic [18:0] v, input logic [31:0] pc, input logic bd);
    MEM_ExceptType = v; MEM_PC = pc; MEM_IsInDelaySlot = bd; MEM_Valid = 1'b1;
  endtask
  task automatic finish_redirect();
    redirect_ready = 1'b1;
    cyc();
    MEM_Valid = 1'b0; MEM_ExceptType = '0; redirect_ready = 1'b0;
  endtask
  initial begin
    m_reset();
    repeat (2) cyc();
    chk("rst_stall", stall_o, 0);
    chk("rst_rpc", redirect_pc, 0);
    resetn = 1'b1;
    // Overflow, no outstanding traffic
    arm(vbit(8), 32'h8000_1000, 1'b0);
    #1 chk("ovf_stall_T", stall_o, 1);
    cyc();
    chk("ovf_flush", flush_o, 1); chk("ovf_we", cp0_exc_we, 1); chk("ovf_code", cp0_exccode, 12);
    chk("ovf_epc", cp0_epc, 32'h8000_1000); chk("ovf_bvwe", cp0_badvaddr_we, 0);
    cyc();
    chk("ovf_rv", redirect_valid, 1); chk("ovf_rpc", redirect_pc, 32'h8000_0180);
    finish_redirect();
    #1 chk("ovf_stall_done", stall_o, 0);
    // Read address error in a delay slot
    MEM_VAddr = 32'h1003;
    arm(vbit(10), 32'h8000_2004, 1'b1);
    cyc();
    chk("adel_code", cp0_exccode, 4); chk("adel_epc", cp0_epc, 32'h8000_2000);
    chk("adel_bd", cp0_bd, 1); chk("adel_bva", cp0_badvaddr, 32'h1003); chk("adel_bvwe", cp0_badvaddr_we, 1);
    cyc();
    finish_redirect();
    // Store TLB refill with BEV set
    CP0_Status_BEV = 1'b1;
    arm(vbit(14), 32'h8000_2100, 1'b0);
    cyc();
    chk("tlbs_code", cp0_exccode, 3);
    cyc();
    chk("tlbs_rpc", redirect_pc, 32'hBFC0_0200);
    finish_redirect();
    CP0_Status_BEV = 1'b0;
    // Interrupt beats Syscall
    arm(vbit(0) | vbit(6), 32'h8000_2200, 1'b0);
    cyc();
    chk("int_code", cp0_exccode, 0); chk("int_we", cp0_exc_we, 1);
    cyc();
    finish_redirect();
    // Drain two outstanding transactions
    bus_req_fire = 1'b1;
    repeat (2) cyc();
    bus_req_fire = 1'b0;
    arm(vbit(7), 32'h8000_2300, 1'b0);
    cyc();
    chk("drn_flush0", flush_o, 0); chk("drn_stall0", stall_o, 1);
    cyc();
    chk("drn_flush1", flush_o, 0);
    bus_resp_fire = 1'b1;
    cyc();
    chk("drn_flush2", flush_o, 0);
    cyc();
    chk("drn_flush3", flush_o, 1); chk("drn_code", cp0_exccode, 9);
    bus_resp_fire = 1'b0;
    cyc();
    finish_redirect();
    // cnt=1 in drain with simultaneous request and response stays in drain
    bus_req_fire = 1'b1;
    cyc();
    bus_req_fire = 1'b0;
    arm(vbit(9), 32'h8000_2400, 1'b0);
    cyc();
    bus_req_fire = 1'b1; bus_resp_fire = 1'b1;
    cyc();
    chk("both_flush", flush_o, 0); chk("both_stall", stall_o, 1);
    bus_req_fire = 1'b0;
    cyc();
    chk("both_flush2", flush_o, 1);
    bus_resp_fire = 1'b0;
    cyc();
    finish_redirect();
    // ERET with a slow redirect acceptor
    CP0_EPC = 32'h8000_3000;
    arm(vbit(17), 32'h8000_2500, 1'b0);
    cyc();
    chk("eret_pulse", cp0_eret, 1); chk("eret_nowe", cp0_exc_we, 0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("eret_rv_held", redirect_valid, 1); chk("eret_rpc", redirect_pc, 32'h8000_3000);
      cyc();
    end
    chk("eret_rv_last", redirect_valid, 1);
    finish_redirect();
    #1 chk("eret_rv_gone", redirect_valid, 0);
    // Refetch
    arm(vbit(18), 32'h8000_4000, 1'b0);
    cyc();
    chk("rf_flush", flush_o, 1); chk("rf_nowe", cp0_exc_we, 0); chk("rf_noeret", cp0_eret, 0);
    cyc();
    chk("rf_rpc", redirect_pc, 32'h8000_4000);
    finish_redirect();
    // Reset while draining
    bus_req_fire = 1'b1;
    cyc();
    bus_req_fire = 1'b0;
    arm(vbit(12), 32'h8000_5000, 1'b0);
    cyc();
    cyc();
    resetn = 1'b0;
    m_reset();
    #1 chk("rst_mid_stall", stall_o, 0); chk("rst_mid_flush", flush_o, 0); chk("rst_mid_rv", redirect_valid, 0);
    cyc();
    resetn = 1'b1; MEM_Valid = 1'b0; MEM_ExceptType = '0;
    cyc();
    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int preq = (i / 500) % 2 ? 65 : 30;
      resetn            = $urandom_range(0, 399) != 0;
      if (!resetn) m_reset();
      MEM_Valid         = $urandom_range(0, 3) == 0;
      MEM_ExceptType    = vbit($urandom_range(0, 18)) | ($urandom_range(0, 3) == 0 ? vbit($urandom_range(0, 18)) : 19'd0);
      MEM_PC            = $urandom & 32'hFFFF_FFFC;
      MEM_VAddr         = $urandom;
      MEM_IsInDelaySlot = $urandom_range(0, 1);
      CP0_Status_BEV    = $urandom_range(0, 1);
      CP0_EPC           = $urandom;
      bus_req_fire      = $urandom_range(0, 99) < preq;
      bus_resp_fire     = $urandom_range(0, 99) < 35;
      redirect_ready    = $urandom_range(0, 99) < 40;
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exception_commit_ctrl.md
# exception_commit_ctrl

Sequencing controller at the MEM stage that turns the per-instruction exception vector built in EXE into a committed exception. It picks the highest-priority cause and stalls the pipeline while outstanding data-bus transactions drain. It then issues a one-cycle flush with the CP0 update and hands a redirect PC to IF over a valid/ready handshake. It also handles ERET and refetch, which share the same flush/redirect path.

## Interface
Parameters:
- CNT_W, default 3: width of the outstanding-transaction counter (max 2^CNT_W−1 in flight).
- EXC_BASE, default 32'h8000_0000: exception base when Status.BEV=0.
- BEV_BASE, default 32'hBFC0_0200: exception base when Status.BEV=1.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous, active-low reset.
- MEM_Valid  in  1  MEM-stage instruction valid (not a bubble).
- MEM_ExceptType  in  ExceptinPipeType  final exception vector from EXE, registered into MEM.
- MEM_PC  in  32  PC of the MEM instruction.
- MEM_IsInDelaySlot  in  1  instruction sits in a branch delay slot.
- MEM_VAddr  in  32  data virtual address.
- CP0_Status_BEV  in  1  Status.BEV.
- CP0_EPC  in  32  current EPC, used as the ERET target.
- bus_req_fire  in  1  data-bus request accepted this cycle.
- bus_resp_fire  in  1  data-bus response returned this cycle.
- redirect_ready  in  1  IF accepts the redirect.
- stall_o  out  1  freeze IF..MEM.
- flush_o  out  1  kill all younger stages (pulse).
- cp0_exc_we  out  1  write Cause/EPC/Status.EXL (pulse).
- cp0_exccode  out  5  Cause.ExcCode.
- cp0_epc  out  32  EPC value.
- cp0_bd  out  1  Cause.BD.
- cp0_badvaddr_we  out  1  write BadVAddr (pulse).
- cp0_badvaddr  out  32  BadVAddr value.
- cp0_eret  out  1  clear Status.EXL (pulse).
- redirect_valid  out  1  redirect PC valid.
- redirect_pc  out  32  new fetch PC.

## Operation
- Trigger: MEM_Valid=1, state IDLE, and any bit of MEM_ExceptType set.
- Priority, highest first, with ExcCode:
  - Interrupt 0
  - WrongAddressinIF 4
  - TLBRefillinIF 2, TLBInvalidinIF 2
  - ReservedInstruction 10
  - CoprocessorUnusable 11
  - Syscall 8
  - Break 9
  - Overflow 12
  - Trap 13
  - RdWrongAddressinMEM 4, WrWrongAddressinMEM 5
  - RdTLBRefillinMEM 2, RdTLBInvalidinMEM 2
  - WrTLBRefillinMEM 3, WrTLBInvalidinMEM 3
  - TLBModified 1
  - Eret
  - Refetch
- Latched on trigger: kind (EXC/ERET/REFETCH), exccode, epc, bd, badvaddr, badvaddr_we, target.
  - epc = MEM_PC−4 if MEM_IsInDelaySlot, else MEM_PC. bd = MEM_IsInDelaySlot.
  - badvaddr: MEM_PC for IF address/TLB causes; MEM_VAddr for MEM address/TLB/Mod causes. badvaddr_we=1 only for those causes.
  - Target for EXC: base+0x000 for TLB-refill causes (IF or MEM), else base+0x180. base = BEV_BASE if BEV, else EXC_BASE.
  - Target for ERET: CP0_EPC. Target for REFETCH: MEM_PC.
- Outstanding counter cnt: +1 on req_fire, −1 on resp_fire, unchanged if both. Saturates at max and at 0; never wraps. Keeps running in all states.
- States:
  - IDLE → DRAIN on trigger if cnt_next≠0; → FLUSH on trigger if cnt_next=0.
  - DRAIN → FLUSH when cnt_next=0.
  - FLUSH → REDIRECT unconditionally.
  - REDIRECT → IDLE when redirect_valid & redirect_ready.
- FLUSH cycle asserts flush_o=1. For EXC it also asserts cp0_exc_we=1 and cp0_badvaddr_we per latch. For ERET it asserts cp0_eret=1. REFETCH writes no CP0.
- Triggers outside IDLE are ignored; the pipeline is stalled, so the vector is held.

## Timing
- Reset: state IDLE, cnt=0, all outputs 0 (redirect_pc, cp0_* data 0). Reset mid-sequence aborts with no pulses.
- stall_o = (state≠IDLE) | trigger (combinational), so the faulting instruction freezes in cycle T.
- cnt=0 at T: FLUSH at T+1, redirect_valid rises at T+2. Minimum three cycles from trigger to redirect.
- flush_o, cp0_exc_we, cp0_eret and cp0_badvaddr_we are exactly one cycle wide.
- redirect_valid and redirect_pc are registered and held stable until ready. stall_o drops the cycle after the handshake.
- Simultaneous req_fire and resp_fire in DRAIN with cnt=1: stay in DRAIN.

## Test plan
- Overflow at PC=0x8000_1000, BD=0, BEV=0, cnt=0 → T+1: flush_o=1, cp0_exc_we=1, exccode=12, epc=0x8000_1000, badvaddr_we=0; T+2: redirect_pc=0x8000_0180.
- RdWrongAddressinMEM, VAddr=0x1003, BD=1, PC=0x8000_2004 → exccode=4, epc=0x8000_2000, bd=1, badvaddr=0x1003.
- WrTLBRefillinMEM with BEV=1 → exccode=3, redirect_pc=0xBFC0_0200.
- Interrupt and Syscall both set → exccode=0.
- Trigger with cnt=2, one response per cycle two cycles later → stall held, DRAIN for 3 cycles, flush one cycle after cnt reaches 0.
- ERET with CP0_EPC=0x8000_3000, redirect_ready low for 4 cycles → cp0_eret pulse, no cp0_exc_we, redirect_valid held 5 cycles.
- Refetch → flush_o only, redirect_pc=MEM_PC.
- resetn low during DRAIN → all outputs 0 immediately.
